// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle tick into a level pulse of len cycles, then keeps a minimum low gap.
// Optional macro PULSE_STRETCHER_RETRIGGER_EN: a tick while HIGH reloads the pulse length.
module pulse_stretcher #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] len,
  input  logic [WIDTH-1:0] gap,
  output logic             level,
  output logic             busy,
  output logic             dropped
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_dropped;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_drop_nxt;
  logic             w_len_nz;
  logic             w_gap_nz;
  logic             w_cnt_zero;

  assign w_len_nz   = (len != '0);
  assign w_gap_nz   = (gap != '0);
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dropped <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drop_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tick) begin
          if (w_len_nz) begin
            w_state_nxt = S_HIGH;
            w_cnt_nxt   = len - 1'b1;
          end else begin
            w_drop_nxt  = 1'b1;
          end
        end
      end
      S_HIGH: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (tick && w_len_nz) begin
          w_cnt_nxt = len - 1'b1;
        end else begin
          w_drop_nxt = tick;
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else if (w_gap_nz) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = gap - 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
`else
        w_drop_nxt = tick;
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_gap_nz) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = gap - 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
`endif
      end
      S_GAP: begin
        w_drop_nxt = tick;
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decode the state register only, so they never glitch between edges.
  assign level   = (r_state == S_HIGH);
  assign busy    = (r_state != S_IDLE);
  assign dropped = r_dropped;

endmodule
